seg7_io_display: RTL and testbench

Memory-mapped four-digit seven-segment display controller that sits directly downstream of the CPU's I/O write path. When the CPU writes a 16-bit value or a control word through the I/O bus, the block stores it and renders it as hex or decimal digits. It then time-multiplexes the four digits onto the board's seven-segment pins. Decimal rendering uses a sequential 16-iteration double-dabble converter and reports `busy` while it runs.

---
 rtl/seg7_io_display.sv | 171 +++++++++++++++++
 tb/tb_seg7_io_display.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seg7_io_display.sv
// seg7_io_display
// Four-digit seven-segment display controller on the CPU I/O write path.
// A data write stores a 16-bit value. A control write selects hex or decimal
// rendering and leading-zero blanking. Rendered glyphs are held in a display
// register and time-multiplexed onto the segment pins.
//
// Ports:
//   clock     in   CPU clock, rising-edge active
//   reset     in   asynchronous active-low reset
//   io_write  in   I/O write strobe
//   seg_cs    in   chip select from address decode
//   io_addr   in   2'b00 data, 2'b01 control, 2'b1x ignored
//   io_wdata  in   write data
//   busy      out  decimal conversion in progress
//   seg_en    out  digit enables, active-low, bit 0 = rightmost digit
//   seg_out0  out  segments, active-low, {dp,g,f,e,d,c,b,a}
module seg7_io_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_write,
  input  logic        seg_cs,
  input  logic [1:0]  io_addr,
  input  logic [15:0] io_wdata,
  output logic        busy,
  output logic [3:0]  seg_en,
  output logic [7:0]  seg_out0
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  typedef enum logic {S_IDLE = 1'b0, S_CONV = 1'b1} state_t;

  // Active-low glyph for one hex digit.
  function automatic logic [7:0] glyph(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
      4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
      4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
      4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  4'hF: g = 8'h8E;
      default: g = 8'hFF;
    endcase
    return g;
  endfunction

  // Four digit nibbles -> four glyphs {d3,d2,d1,d0}. Overflow shows dashes and
  // bypasses blanking; digit 0 is never blanked.
  function automatic logic [31:0] render(input logic [15:0] n, input logic ovf,
                                         input logic lzb);
    logic [31:0] r;
    logic        z3, z32, z321;
    z3   = (n[15:12] == 4'd0);
    z32  = z3 && (n[11:8] == 4'd0);
    z321 = z32 && (n[7:4] == 4'd0);
    if (ovf) begin
      r = {4{8'hBF}};
    end else begin
      r[31:24] = (lzb && z3)   ? 8'hFF : glyph(n[15:12]);
      r[23:16] = (lzb && z32)  ? 8'hFF : glyph(n[11:8]);
      r[15:8]  = (lzb && z321) ? 8'hFF : glyph(n[7:4]);
      r[7:0]   = glyph(n[3:0]);
    end
    return r;
  endfunction

  // One double-dabble step on {bcd[19:0], bin[15:0]}: add 3 to BCD nibbles
  // that are 5 or more, then shift the whole register left by one.
  function automatic logic [35:0] dd_step(input logic [35:0] s);
    logic [19:0] b;
    logic [3:0]  nib;
    for (int i = 0; i < 5; i++) begin
      nib = s[16 + 4*i +: 4];
      b[4*i +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
    return {b[18:0], s[15:0], 1'b0};
  endfunction

  state_t       r_state, w_state_nxt;
  logic [15:0]  r_value;
  logic         r_mode, r_lzb;
  logic [31:0]  r_disp, w_disp_nxt;
  logic [35:0]  r_shift, w_shift_nxt, w_step;
  logic [3:0]   r_iter, w_iter_nxt;
  logic [PW-1:0] r_presc;
  logic [1:0]   r_idx;

  logic         w_accept, w_is_data, w_new_mode, w_new_lzb;
  logic [15:0]  w_new_value;

  assign w_accept    = io_write & seg_cs & ~io_addr[1];
  assign w_is_data   = ~io_addr[0];
  assign w_new_value = w_is_data ? io_wdata : r_value;
  assign w_new_mode  = w_is_data ? r_mode : io_wdata[0];
  assign w_new_lzb   = w_is_data ? r_lzb : io_wdata[1];
  assign w_step      = dd_step(r_shift);

  // Render control: a new write always wins, restarting any conversion.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_iter_nxt  = r_iter;
    w_disp_nxt  = r_disp;
    if (w_accept) begin
      w_iter_nxt = 4'd0;
      if (w_new_mode) begin
        w_state_nxt = S_CONV;
        w_shift_nxt = {20'd0, w_new_value};
      end else begin
        w_state_nxt = S_IDLE;
        w_disp_nxt  = render(w_new_value, 1'b0, w_new_lzb);
      end
    end else if (r_state == S_CONV) begin
      w_shift_nxt = w_step;
      w_iter_nxt  = r_iter + 4'd1;
      if (r_iter == 4'd15) begin
        w_state_nxt = S_IDLE;
        w_disp_nxt  = render(w_step[31:16], (w_step[35:32] != 4'd0), r_lzb);
      end else begin
        w_state_nxt = S_CONV;
      end
    end else begin
      w_state_nxt = S_IDLE;
    end
  end

  // Register file, converter state and display register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_value <= 16'd0;
      r_mode  <= 1'b0;
      r_lzb   <= 1'b0;
      r_shift <= 36'd0;
      r_iter  <= 4'd0;
      r_disp  <= {4{8'hC0}};
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_value <= w_new_value & {16{w_accept}} | r_value & {16{~w_accept}};
      r_mode  <= w_accept ? w_new_mode : r_mode;
      r_lzb   <= w_accept ? w_new_lzb : r_lzb;
      r_shift <= w_shift_nxt;
      r_iter  <= w_iter_nxt;
      r_disp  <= w_disp_nxt;
      busy    <= (w_state_nxt == S_CONV);
    end
  end

  // Digit scan: prescaler wraps with no gap; outputs registered from idx.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_presc  <= '0;
      r_idx    <= 2'd0;
      seg_en   <= 4'hF;
      seg_out0 <= 8'hFF;
    end else begin
      if (r_presc == PMAX) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + {{(PW-1){1'b0}}, 1'b1};
      end
      seg_en   <= ~(4'b0001 << r_idx);
      seg_out0 <= r_disp[8*r_idx +: 8];
    end
  end

endmodule

// File: tb/tb_seg7_io_display.sv
// Directed, table-driven bench for seg7_io_display with SCAN_DIV=4.
module tb_seg7_io_display;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_write = 1'b0;
  logic        seg_cs = 1'b0;
  logic [1:0]  io_addr = 2'b00;
  logic [15:0] io_wdata = 16'h0000;
  logic        busy;
  logic [3:0]  seg_en;
  logic [7:0]  seg_out0;

  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;
  logic saw_f9 = 1'b0;

  seg7_io_display #(.SCAN_DIV(4)) dut (
    .clock(clock), .reset(reset), .io_write(io_write), .seg_cs(seg_cs),
    .io_addr(io_addr), .io_wdata(io_wdata), .busy(busy),
    .seg_en(seg_en), .seg_out0(seg_out0)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (mon_en && seg_out0 == 8'hF9) saw_f9 = 1'b1;

  typedef struct {
    logic        cs;
    logic [1:0]  addr;
    logic [15:0] data;
    int          busy_n;
    logic [31:0] glyphs; // {d3,d2,d1,d0}
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic do_write(input logic cs, input logic [1:0] addr, input logic [15:0] data);
    io_write = 1'b1; seg_cs = cs; io_addr = addr; io_wdata = data;
    @(posedge clock);
    @(negedge clock);
    io_write = 1'b0; seg_cs = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic capture(input string tag, input logic [31:0] exp);
    logic [7:0] got [4];
    for (int d = 0; d < 4; d++) got[d] = 8'h00;
    @(negedge clock);
    for (int c = 0; c < 20; c++) begin
      case (seg_en)
        4'b1110: got[0] = seg_out0;
        4'b1101: got[1] = seg_out0;
        4'b1011: got[2] = seg_out0;
        4'b0111: got[3] = seg_out0;
        default: ;
      endcase
      @(negedge clock);
    end
    for (int d = 0; d < 4; d++)
      chk($sformatf("%s_d%0d", tag, d), {24'd0, got[d]}, {24'd0, exp[8*d +: 8]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] exp_en;

    vecs[0]  = '{1'b1, 2'b00, 16'h1A2F, 0,  {8'hF9, 8'h88, 8'hA4, 8'h8E}};
    vecs[1]  = '{1'b1, 2'b01, 16'h0003, 16, {8'h82, 8'hF8, 8'hC0, 8'hB0}}; // 6703
    vecs[2]  = '{1'b1, 2'b00, 16'd42,   16, {8'hFF, 8'hFF, 8'h99, 8'hA4}};
    vecs[3]  = '{1'b1, 2'b00, 16'd12345,16, {4{8'hBF}}};
    vecs[4]  = '{1'b1, 2'b00, 16'd9999, 16, {4{8'h90}}};
    vecs[5]  = '{1'b1, 2'b00, 16'd0,    16, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[6]  = '{1'b1, 2'b01, 16'h0001, 16, {4{8'hC0}}};
    vecs[7]  = '{1'b1, 2'b01, 16'h0002, 0,  {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[8]  = '{1'b1, 2'b00, 16'h00F0, 0,  {8'hFF, 8'hFF, 8'h8E, 8'hC0}};
    vecs[9]  = '{1'b1, 2'b11, 16'h0001, 0,  {8'hFF, 8'hFF, 8'h8E, 8'hC0}}; // ignored
    vecs[10] = '{1'b0, 2'b00, 16'h5555, 0,  {8'hFF, 8'hFF, 8'h8E, 8'hC0}}; // no cs
    vecs[11] = '{1'b1, 2'b01, 16'h0000, 0,  {8'hC0, 8'hC0, 8'h8E, 8'hC0}};
    vecs[12] = '{1'b1, 2'b01, 16'h0001, 16, {8'hC0, 8'hA4, 8'h99, 8'hC0}}; // 240

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_en", {28'd0, seg_en}, 32'hF);
    chk("rst_seg", {24'd0, seg_out0}, 32'hFF);

    // Scan sequence after release
    reset = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      exp_en = 4'b0001 << (k / 4);
      exp_en = ~exp_en;
      chk($sformatf("scan_en_%0d", k), {28'd0, seg_en}, {28'd0, exp_en});
      chk($sformatf("scan_seg_%0d", k), {24'd0, seg_out0}, 32'hC0);
    end

    // Table of single writes
    for (int v = 0; v < 13; v++) begin
      do_write(vecs[v].cs, vecs[v].addr, vecs[v].data);
      count_busy(n);
      chk($sformatf("v%0d_busy", v), n, vecs[v].busy_n);
      capture($sformatf("v%0d", v), vecs[v].glyphs);
    end

    // Restart during conversion: 100 then 7 five cycles later
    saw_f9 = 1'b0;
    mon_en = 1'b1;
    do_write(1'b1, 2'b00, 16'd100);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy) n++;
      if (i < 4) @(negedge clock);
    end
    do_write(1'b1, 2'b00, 16'd7);
    begin
      int m;
      count_busy(m);
      n = n + m;
    end
    chk("restart_busy", n, 21);
    capture("restart", {8'hC0, 8'hC0, 8'hC0, 8'hF8});
    mon_en = 1'b0;
    chk("restart_no100", {31'd0, saw_f9}, 32'd0);

    // Reset in the middle of a conversion
    do_write(1'b1, 2'b00, 16'd500);
    repeat (3) @(negedge clock);
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_en", {28'd0, seg_en}, 32'hF);
    chk("mid_rst_seg", {24'd0, seg_out0}, 32'hFF);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_en", {28'd0, seg_en}, 32'hE);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    capture("post_rst", {4{8'hC0}});
    do_write(1'b1, 2'b00, 16'h00AB);
    count_busy(n);
    chk("post_rst_hex_busy", n, 0);
    capture("post_rst_hex", {8'hC0, 8'hC0, 8'h88, 8'h83});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
